// File: rtl/dram_pkg.sv
// Shared types for the memory request issuer: data word, queue entry, FSM states.
package dram_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Legacy-compatible state encodings, reused as the enum values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    RESP  = ST_RESP
  } issuer_state_t;

  // One queued front-end request.
  typedef struct packed {
    logic  wen;
    addr_t addr;
    word_t wdata;
  } req_entry_t;

  localparam int unsigned ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/mem_req_issuer_if.sv
// Front-end request, read-response and DRAM controller signals of the issuer.
interface mem_req_issuer_if;
  import dram_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_wen;
  addr_t req_addr;
  word_t req_wdata;

  logic  rsp_valid;
  logic  rsp_ready;
  word_t rsp_rdata;

  logic  dREN;
  logic  dWEN;
  addr_t ram_addr;
  word_t ramstore;
  word_t ramload;
  logic  ram_wait;

  // Environment side: front-end requester, response consumer and DRAM controller.
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, rsp_ready, ramload, ram_wait,
    input  req_ready, rsp_valid, rsp_rdata, dREN, dWEN, ram_addr, ramstore
  );

  // Issuer side.
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, rsp_ready, ramload, ram_wait,
    output req_ready, rsp_valid, rsp_rdata, dREN, dWEN, ram_addr, ramstore
  );
endinterface

// File: rtl/req_fifo.sv
// Request queue with registered full/empty flags and a combinational head.
module req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop, full_nxt, empty_nxt;

  // A push while full is refused even when a pop frees a slot that cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer advance wraps modulo 2*DEPTH; flags come from the next pointers.
  always_comb begin
    wr_nxt    = wr_ptr + PW'(do_push);
    rd_nxt    = rd_ptr + PW'(do_pop);
    empty_nxt = (wr_nxt == rd_nxt);
    full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  end

  // Pointer and flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= full_nxt;
      empty  <= empty_nxt;
    end
  end

  // Storage array; contents are don't-care while the queue is empty.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_req_issuer.sv
// Queues front-end memory requests and issues them one at a time to a DRAM controller.
module mem_req_issuer
  import dram_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  mem_req_issuer_if.slave   bus,
  output logic [LAT_W-1:0]  last_lat
);

  issuer_state_t state, state_nxt;

  logic [ENTRY_W-1:0] head_c;
  req_entry_t         head, req_in;
  logic               fifo_full, fifo_empty, push, pop_c;

  logic               dren_q, dwen_q, rsp_valid_q;
  addr_t              ram_addr_q;
  word_t              ramstore_q, rsp_rdata_q;
  logic [LAT_W-1:0]   lat_cnt, last_lat_q;

  logic               dren_nxt, dwen_nxt, rsp_valid_nxt;
  addr_t              addr_nxt;
  word_t              store_nxt, rdata_nxt;
  logic [LAT_W-1:0]   lat_nxt, last_nxt, lat_inc;

  assign req_in = '{wen: bus.req_wen, addr: bus.req_addr, wdata: bus.req_wdata};
  assign push   = bus.req_valid && bus.req_ready;
  assign head   = head_c;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .push   (push),
    .pop    (pop_c),
    .din    (req_in),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Latency count for the current ISSUE cycle, saturating at all-ones.
  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    pop_c         = 1'b0;
    dren_nxt      = 1'b0;
    dwen_nxt      = 1'b0;
    addr_nxt      = ram_addr_q;
    store_nxt     = ramstore_q;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata_q;
    lat_nxt       = lat_cnt;
    last_nxt      = last_lat_q;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ISSUE;
          dren_nxt  = !head.wen;
          dwen_nxt  = head.wen;
          addr_nxt  = head.addr;
          store_nxt = head.wdata;
          lat_nxt   = '0;
        end
      end
      ISSUE: begin
        lat_nxt = lat_inc;
        if (!bus.ram_wait) begin
          pop_c    = 1'b1;
          last_nxt = lat_inc;
          if (head.wen) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rdata_nxt     = bus.ramload;
          end
        end else begin
          dren_nxt = dren_q;
          dwen_nxt = dwen_q;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      ram_addr_q  <= '0;
      ramstore_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      lat_cnt     <= '0;
      last_lat_q  <= '0;
    end else begin
      state       <= state_nxt;
      dren_q      <= dren_nxt;
      dwen_q      <= dwen_nxt;
      ram_addr_q  <= addr_nxt;
      ramstore_q  <= store_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rdata_nxt;
      lat_cnt     <= lat_nxt;
      last_lat_q  <= last_nxt;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.dREN      = dren_q;
  assign bus.dWEN      = dwen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ramstore  = ramstore_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign last_lat      = last_lat_q;

endmodule
